// File: rtl/all_pkgs.sv
// Shared core-wide types and constants: datapath width, writeback source
// select, load funct3 codes and the writeback FSM state encoding.
package all_pkgs;

   localparam int WIDTH = 32;

   typedef enum logic [2:0] {
      WB_ALU = 3'b000,
      WB_MEM = 3'b001,
      WB_PC4 = 3'b010,
      WB_IMM = 3'b011,
      WB_CSR = 3'b100
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      WB_EMPTY    = 2'd0,
      WB_WAIT_MEM = 2'd1,
      WB_COMMIT   = 2'd2
   } wb_state_e;

endpackage

// File: rtl/load_formatter.sv
// Combinational sub-word load extraction: picks the byte/half lane from an
// aligned memory word and sign- or zero-extends it according to funct3.
module load_formatter
   import all_pkgs::*;
(
   input  logic [WIDTH-1:0] raw,
   input  logic [2:0]       funct3,
   input  logic [1:0]       addr_lo,
   output logic [WIDTH-1:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
   always_comb begin
      byte_lane = raw[7:0];
      case (addr_lo)
         2'd0: byte_lane = raw[7:0];
         2'd1: byte_lane = raw[15:8];
         2'd2: byte_lane = raw[23:16];
         2'd3: byte_lane = raw[31:24];
         default: byte_lane = raw[7:0];
      endcase
      half_lane = addr_lo[1] ? raw[31:16] : raw[15:0];

      data = '0;
      case (funct3)
         F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
         F3_LBU:  data = {24'd0, byte_lane};
         F3_LH:   data = {{16{half_lane[15]}}, half_lane};
         F3_LHU:  data = {16'd0, half_lane};
         F3_LW:   data = raw;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Registered MEM/WB writeback stage: accepts one instruction per handshake,
// waits for load data when needed, and issues one register-file write each.
module writeback_stage
   import all_pkgs::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_reg_write,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [2:0]            in_wb_sel,
   input  logic [2:0]            in_funct3,
   input  logic [1:0]            in_addr_lo,
   input  logic [WIDTH-1:0]      in_alu_result,
   input  logic [WIDTH-1:0]      in_pc_plus4,
   input  logic [WIDTH-1:0]      in_imm,
   input  logic [WIDTH-1:0]      in_csr_data,
   input  logic                  mem_rsp_valid,
   input  logic [WIDTH-1:0]      mem_rsp_data,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_rd,
   output logic [WIDTH-1:0]      rf_wdata,
   output logic                  busy
);

   wb_state_e             state_q, state_d;
   logic                  reg_write_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [2:0]            funct3_q;
   logic [1:0]            addr_lo_q;

   logic                  accept;
   logic [WIDTH-1:0]      sel_data;
   logic [WIDTH-1:0]      fmt_data;
   logic                  commit_en;
   logic                  commit_we;
   logic [REG_ADDR_W-1:0] commit_rd;
   logic [WIDTH-1:0]      commit_data;

   load_formatter u_load_formatter (
      .raw     (mem_rsp_data),
      .funct3  (funct3_q),
      .addr_lo (addr_lo_q),
      .data    (fmt_data)
   );

   always_comb begin
      sel_data = '0;
      case (in_wb_sel)
         WB_ALU:  sel_data = in_alu_result;
         WB_PC4:  sel_data = in_pc_plus4;
         WB_IMM:  sel_data = in_imm;
         WB_CSR:  sel_data = in_csr_data;
         default: sel_data = '0;
      endcase
   end

   always_comb begin
      in_ready    = !flush && (state_q == WB_EMPTY || state_q == WB_COMMIT);
      accept      = in_valid && in_ready;
      state_d     = state_q;
      commit_en   = 1'b0;
      commit_we   = 1'b0;
      commit_rd   = rd_q;
      commit_data = fmt_data;

      case (state_q)
         WB_EMPTY, WB_COMMIT: begin
            if (!accept) begin
               state_d = WB_EMPTY;
            end else if (in_wb_sel == WB_MEM) begin
               state_d = WB_WAIT_MEM;
            end else begin
               state_d     = WB_COMMIT;
               commit_en   = 1'b1;
               commit_we   = in_reg_write && (in_rd != '0);
               commit_rd   = in_rd;
               commit_data = sel_data;
            end
         end
         WB_WAIT_MEM: begin
            // Flush beats a same-cycle response: the load is dropped unwritten.
            if (flush) begin
               state_d = WB_EMPTY;
            end else if (mem_rsp_valid) begin
               state_d   = WB_COMMIT;
               commit_en = 1'b1;
               commit_we = reg_write_q && (rd_q != '0);
            end
         end
         default: state_d = WB_EMPTY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= WB_EMPTY;
         reg_write_q <= 1'b0;
         rd_q        <= '0;
         funct3_q    <= '0;
         addr_lo_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            reg_write_q <= in_reg_write;
            rd_q        <= in_rd;
            funct3_q    <= in_funct3;
            addr_lo_q   <= in_addr_lo;
         end
      end
   end

   // Output registers double as the WB forwarding source; address/data hold between writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_rd    <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= commit_we;
         if (commit_en) begin
            rf_rd    <= commit_rd;
            rf_wdata <= commit_data;
         end
      end
   end

   assign busy = (state_q != WB_EMPTY);

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_writeback_stage;
   import all_pkgs::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        in_reg_write;
   logic [4:0]  in_rd;
   logic [2:0]  in_wb_sel;
   logic [2:0]  in_funct3;
   logic [1:0]  in_addr_lo;
   logic [31:0] in_alu_result, in_pc_plus4, in_imm, in_csr_data;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic        busy;

   always #5 clk = ~clk;

   writeback_stage #(.REG_ADDR_W(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_reg_write  (in_reg_write),
      .in_rd         (in_rd),
      .in_wb_sel     (in_wb_sel),
      .in_funct3     (in_funct3),
      .in_addr_lo    (in_addr_lo),
      .in_alu_result (in_alu_result),
      .in_pc_plus4   (in_pc_plus4),
      .in_imm        (in_imm),
      .in_csr_data   (in_csr_data),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .rf_we         (rf_we),
      .rf_rd         (rf_rd),
      .rf_wdata      (rf_wdata),
      .busy          (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   // Behavioural model: a load may be outstanding; at most one write per cycle.
   bit          m_wait;
   bit          m_busy;
   bit          m_p_we;
   logic [4:0]  m_p_rd;
   logic [2:0]  m_p_f3;
   logic [1:0]  m_p_addr;

   function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [2:0] f3,
                                            input logic [1:0] addr);
      int unsigned w, b, h;
      w = raw;
      b = (w >> (8 * int'(addr))) % 256;
      h = (w >> (16 * (int'(addr) / 2))) % 65536;
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd5:    return h;
         3'd2:    return w;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_result(input logic [2:0] sel);
      case (sel)
         3'd0:    return in_alu_result;
         3'd2:    return in_pc_plus4;
         3'd3:    return in_imm;
         3'd4:    return in_csr_data;
         default: return 32'd0;
      endcase
   endfunction

   // One clock: check in_ready, advance the model, check registered outputs after the edge.
   task automatic cycle(input string tag);
      bit          exp_ready, commit, exp_we;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
      #1;
      exp_ready = !flush && !m_wait;
      check({tag, " in_ready"}, in_ready, exp_ready);
      commit   = 0;
      exp_we   = 0;
      exp_rd   = '0;
      exp_data = '0;
      if (m_wait) begin
         if (flush) begin
            m_wait = 0;
         end else if (mem_rsp_valid) begin
            m_wait   = 0;
            commit   = 1;
            exp_we   = m_p_we && (m_p_rd != 0);
            exp_rd   = m_p_rd;
            exp_data = ref_load(mem_rsp_data, m_p_f3, m_p_addr);
         end
      end else if (in_valid && exp_ready) begin
         if (in_wb_sel == 3'd1) begin
            m_wait   = 1;
            m_p_we   = in_reg_write;
            m_p_rd   = in_rd;
            m_p_f3   = in_funct3;
            m_p_addr = in_addr_lo;
         end else begin
            commit   = 1;
            exp_we   = in_reg_write && (in_rd != 0);
            exp_rd   = in_rd;
            exp_data = ref_result(in_wb_sel);
         end
      end
      m_busy = m_wait || commit;
      @(posedge clk);
      #1;
      check({tag, " rf_we"}, rf_we, exp_we);
      check({tag, " busy"}, busy, m_busy);
      if (exp_we) begin
         check({tag, " rf_rd"}, rf_rd, exp_rd);
         check({tag, " rf_wdata"}, rf_wdata, exp_data);
      end
   endtask

   task automatic idle();
      in_valid      = 0;
      flush         = 0;
      mem_rsp_valid = 0;
   endtask

   task automatic issue(input logic [2:0] sel, input logic [4:0] rd, input logic rw,
                        input logic [31:0] val);
      in_valid      = 1;
      in_wb_sel     = sel;
      in_rd         = rd;
      in_reg_write  = rw;
      in_alu_result = val;
      in_pc_plus4   = val ^ 32'h5A5A_0000;
      in_imm        = val ^ 32'h0000_A5A5;
      in_csr_data   = ~val;
      if (sel == 3'd2) in_pc_plus4 = val;
      if (sel == 3'd3) in_imm      = val;
      if (sel == 3'd4) in_csr_data = val;
   endtask

   task automatic issue_load(input logic [2:0] f3, input logic [4:0] rd, input logic [1:0] addr);
      issue(3'd1, rd, 1'b1, 32'hDEAD_BEEF);
      in_funct3  = f3;
      in_addr_lo = addr;
   endtask

   // Accept a load, wait two empty cycles, then deliver the response.
   task automatic run_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [1:0] addr, input logic [31:0] exp_lit);
      issue_load(f3, rd, addr);
      mem_rsp_valid = 1;
      mem_rsp_data  = 32'h1111_1111;
      cycle({tag, " accept"});
      idle();
      cycle({tag, " wait1"});
      cycle({tag, " wait2"});
      mem_rsp_valid = 1;
      mem_rsp_data  = 32'h80FF_0102;
      cycle({tag, " rsp"});
      check({tag, " literal"}, rf_wdata, exp_lit);
      idle();
      cycle({tag, " after"});
   endtask

   initial begin
      rst = 1;
      idle();
      in_reg_write = 0; in_rd = 0; in_wb_sel = 0; in_funct3 = 0; in_addr_lo = 0;
      in_alu_result = 0; in_pc_plus4 = 0; in_imm = 0; in_csr_data = 0; mem_rsp_data = 0;
      m_wait = 0; m_busy = 0; m_p_we = 0; m_p_rd = 0; m_p_f3 = 0; m_p_addr = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset rf_we", rf_we, 0);
      check("reset rf_rd", rf_rd, 0);
      check("reset rf_wdata", rf_wdata, 0);
      check("reset busy", busy, 0);
      @(negedge clk);
      rst = 0;

      // Single ALU op then three back-to-back ops of other sources.
      issue(3'd0, 5'd5, 1, 32'h0000_1234); cycle("alu");
      check("alu literal", rf_wdata, 32'h0000_1234);
      issue(3'd2, 5'd6, 1, 32'h0000_0104); cycle("pc4");
      issue(3'd3, 5'd7, 1, 32'hABCD_E000); cycle("imm");
      issue(3'd4, 5'd8, 1, 32'h0000_0008); cycle("csr");
      check("csr literal", rf_wdata, 32'h0000_0008);
      idle(); cycle("b2b drain");
      cycle("b2b empty");

      run_load("lb",  3'd0, 5'd7, 2'd3, 32'hFFFF_FF80);
      run_load("lbu", 3'd4, 5'd7, 2'd3, 32'h0000_0080);
      run_load("lh",  3'd1, 5'd7, 2'd2, 32'hFFFF_80FF);
      run_load("lhu", 3'd5, 5'd7, 2'd0, 32'h0000_0102);

      // Suppressed writes still flow through the stage.
      issue_load(3'd2, 5'd0, 2'd0); cycle("ld rd0 accept");
      idle(); mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_F00D; cycle("ld rd0 rsp");
      issue(3'd0, 5'd3, 0, 32'h7777_7777); cycle("alu nowrite");
      issue(3'd5, 5'd4, 1, 32'h1234_5678); cycle("reserved sel");
      idle(); cycle("suppress drain");

      // Flush racing a load response in WAIT_MEM.
      issue_load(3'd2, 5'd9, 2'd0); cycle("flush ld accept");
      flush = 1; mem_rsp_valid = 1; mem_rsp_data = 32'h0BAD_0BAD; in_valid = 1; in_wb_sel = 3'd0;
      cycle("flush vs rsp");
      idle(); mem_rsp_valid = 1; cycle("stray rsp");
      idle(); cycle("flush empty");

      // Flush during COMMIT: current write completes, next accept deferred.
      issue(3'd0, 5'd10, 1, 32'h0000_AAAA); cycle("commit accept");
      issue(3'd0, 5'd11, 1, 32'h0000_BBBB); flush = 1; cycle("flush in commit");
      flush = 0; cycle("deferred accept");
      idle(); cycle("deferred drain");

      // Async reset while waiting for load data.
      issue_load(3'd2, 5'd12, 2'd0); cycle("rst ld accept");
      idle(); cycle("rst ld wait");
      rst = 1; #1;
      check("rst mid-wait rf_we", rf_we, 0);
      check("rst mid-wait busy", busy, 0);
      m_wait = 0; m_busy = 0;
      @(negedge clk); rst = 0;
      mem_rsp_valid = 1; mem_rsp_data = 32'h5555_5555; cycle("rsp after rst");
      idle(); cycle("post rst");

      // Async reset during COMMIT kills the pending write immediately.
      issue(3'd0, 5'd13, 1, 32'h0000_1313); cycle("rst commit accept");
      idle();
      rst = 1; #1;
      check("rst mid-commit rf_we", rf_we, 0);
      check("rst mid-commit busy", busy, 0);
      m_wait = 0; m_busy = 0;
      @(negedge clk); rst = 0;
      cycle("post rst2");

      for (int i = 0; i < 400; i++) begin
         in_valid      = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 9) == 0);
         in_reg_write  = ($urandom_range(0, 7) != 0);
         in_rd         = 5'($urandom_range(0, 31));
         in_wb_sel     = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
         in_funct3     = 3'($urandom_range(0, 7));
         in_addr_lo    = 2'($urandom_range(0, 3));
         in_alu_result = $urandom;
         in_pc_plus4   = $urandom;
         in_imm        = $urandom;
         in_csr_data   = $urandom;
         mem_rsp_valid = ($urandom_range(0, 9) < 4);
         mem_rsp_data  = $urandom;
         cycle("rnd");
      end
      idle(); cycle("final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Registered MEM/WB writeback stage for the RISC-V core; successor to the plain combinational writeback select.
- Accepts one retiring instruction per handshake and selects among five result sources.
- Waits a variable number of cycles for load data, formats sub-word loads (LB/LH/LW/LBU/LHU), then drives one register-file write per instruction.
- Sits between the memory stage and the register file; its registered outputs also serve as the WB forwarding source.

Parameters:
- WIDTH, 32, datapath width; taken from all_pkgs; must be 32 for load formatting.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  kill any instruction waiting for load data; block acceptance this cycle
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_reg_write  in  1  instruction writes rd
- in_rd  in  REG_ADDR_W  destination register
- in_wb_sel  in  3  wb_sel_e: 000 ALU, 001 MEM, 010 PC4, 011 IMM, 100 CSR
- in_funct3  in  3  load size/sign (RISC-V funct3)
- in_addr_lo  in  2  load address bits [1:0]
- in_alu_result, in_pc_plus4, in_imm, in_csr_data  in  WIDTH each  result sources
- mem_rsp_valid  in  1  load data valid
- mem_rsp_data  in  WIDTH  raw aligned word from data memory
- rf_we  out  1  register-file write enable
- rf_rd  out  REG_ADDR_W  write address
- rf_wdata  out  WIDTH  write data
- busy  out  1  state != EMPTY

Behaviour:
- Reset (async on rst high): state=EMPTY; rf_we=0, rf_rd=0, rf_wdata=0, busy=0; all captured fields cleared.
- FSM states: EMPTY, WAIT_MEM, COMMIT.
- in_ready = !flush && (state==EMPTY || state==COMMIT). Accept = in_valid && in_ready.
- Accepted instruction with in_wb_sel != MEM:
  - Result is selected and registered at accept.
  - Next state is COMMIT.
  - Latency is 1: accept in cycle N, rf_we high in cycle N+1.
- Accepted instruction with in_wb_sel == MEM:
  - Next state is WAIT_MEM. mem_rsp_valid is sampled only while in WAIT_MEM; a response in the accept cycle is ignored.
  - In WAIT_MEM with mem_rsp_valid=1: the formatted word is registered and next state is COMMIT, so rf_we is high the cycle after the response.
  - mem_rsp_valid=0 holds WAIT_MEM indefinitely.
- COMMIT:
  - rf_we = captured reg_write && (rd != 0). An rd==0 write is suppressed but still takes the COMMIT cycle.
  - rf_rd/rf_wdata hold the captured values. rf_we is high for exactly one cycle per instruction.
  - Exit: a new accept goes to COMMIT or WAIT_MEM as above; otherwise EMPTY.
  - Back-to-back non-loads sustain 1 instruction per cycle.
- rf_rd and rf_wdata keep their last values when rf_we=0.
- Load formatting (pure function, used on mem_rsp_data):
  - Byte lane = addr_lo; half lane = addr_lo[1]; LW ignores addr_lo.
  - funct3 000 LB sign-extend; 100 LBU zero-extend; 001 LH sign-extend; 101 LHU zero-extend; 010 LW.
  - Any other funct3 gives 0.
- Reserved in_wb_sel (101–111): data is 0; the write still follows in_reg_write.
- Flush:
  - In WAIT_MEM, flush sends the stage to EMPTY with no write; a later stray mem_rsp_valid in EMPTY is ignored.
  - In COMMIT, the current write still completes (already committed); next state is EMPTY because accept is blocked.
  - flush together with mem_rsp_valid in WAIT_MEM: flush wins, no write.
- rst asserted mid-WAIT_MEM or mid-COMMIT: immediate EMPTY; no write is issued after reset release.

Decomposition:
- Add to all_pkgs:
  - wb_sel_e enum (3-bit).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - wb_state_e enum.
  - Reuse of WIDTH.
- Sub-module load_formatter: combinational; inputs raw word, funct3, addr_lo; output extended word. Reusable by a future LSU.

Test Plan:
- Reset mid-WAIT_MEM → rf_we=0, busy=0; subsequent mem_rsp_valid=1 produces no write.
- ALU op rd=5, alu_result=0x0000_1234, accepted cycle N → cycle N+1: rf_we=1, rf_rd=5, rf_wdata=0x0000_1234. Three back-to-back ops (PC4=0x104, IMM=0xABCD_E000, CSR=0x8) → three consecutive rf_we cycles with matching data.
- LB rd=7, addr_lo=3, mem_rsp_data=0x80FF_0102 returned 3 cycles after accept, in_ready=0 while waiting → rf_wdata=0xFFFF_FF80, rf_we exactly once. Repeat as LBU → 0x0000_0080. LH addr_lo=2 → 0xFFFF_80FF. LHU addr_lo=0 → 0x0000_0102.
- Load with rd=0, or ALU op with reg_write=0 → rf_we stays 0; stage still returns to EMPTY/accepts next.
- flush in WAIT_MEM in the same cycle as mem_rsp_valid → no write, state EMPTY, in_ready=0 that cycle, 1 next cycle.
- flush during COMMIT with in_valid=1 → current write occurs, new instruction not accepted (in_ready=0), accepted the following cycle.
